// File: rtl/compare_sort_ctrl_pkg.sv
// Shared constants for the in-place byte sorter: FSM encodings, comparator bit
// positions, index sizing and the swap decision.
package compare_sort_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CMP   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int CMP_GT = 2;
    localparam int CMP_EQ = 1;
    localparam int CMP_LT = 0;

    localparam int DEPTH_MAX = 8;
    localparam int IDX_W     = $clog2(DEPTH_MAX);

    // Equal operands never swap, which keeps the sort stable.
    function automatic logic want_swap(input logic [2:0] rel, input logic desc);
        return !rel[CMP_EQ] && (desc ? rel[CMP_LT] : rel[CMP_GT]);
    endfunction

endpackage

// File: rtl/compare_sort_ctrl_cmp8.sv
// 8-bit magnitude comparator; one-hot relation of a to b, purely combinational.
module compare_sort_ctrl_cmp8
    import compare_sort_ctrl_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [2:0] rel
);

    always_comb begin
        rel         = '0;
        rel[CMP_GT] = (a > b);
        rel[CMP_EQ] = (a == b);
        rel[CMP_LT] = (a < b);
    end

endmodule

// File: rtl/compare_sort_ctrl.sv
// Loads DEPTH bytes, bubble-sorts them in place with one shared comparator
// (one compare per clock, early exit on a clean pass), then drains the block.
module compare_sort_ctrl
    import compare_sort_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter bit ORDER = 1'b0
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic [5:0] cmp_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [1:0]       state;
    logic [7:0]       entry [DEPTH_MAX];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] pass;
    logic             swapped;

    logic [IDX_W-1:0] j_nxt;
    logic [IDX_W-1:0] j_end;
    logic [7:0]       cmp_a;
    logic [7:0]       cmp_b;
    logic [2:0]       rel;
    logic             do_swap;
    logic             pass_done;

    // Array is sized to the maximum depth so every index value is in range.
    assign j_nxt     = j + IDX_ONE;
    assign j_end     = LAST_PASS - pass;
    assign cmp_a     = entry[j];
    assign cmp_b     = entry[j_nxt];
    assign do_swap   = want_swap(rel, ORDER);
    assign pass_done = (j == j_end);

    compare_sort_ctrl_cmp8 u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .rel (rel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            wr_idx  <= '0;
            rd_idx  <= '0;
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            cmp_cnt <= '0;
            for (int i = 0; i < DEPTH_MAX; i++) begin
                entry[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        entry[wr_idx] <= in_data;
                        if (wr_idx == '0) begin
                            cmp_cnt <= '0;
                        end
                        if (wr_idx == LAST_IDX) begin
                            wr_idx  <= '0;
                            j       <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                            state   <= ST_CMP;
                        end else begin
                            wr_idx <= wr_idx + IDX_ONE;
                        end
                    end
                end
                ST_CMP: begin
                    if (cmp_cnt != 6'h3f) begin
                        cmp_cnt <= cmp_cnt + 6'd1;
                    end
                    if (do_swap) begin
                        entry[j]     <= cmp_b;
                        entry[j_nxt] <= cmp_a;
                    end
                    // Pass bookkeeping folds into the last compare of the pass.
                    if (pass_done) begin
                        if (!(swapped || do_swap) || (pass == LAST_PASS)) begin
                            rd_idx <= '0;
                            state  <= ST_DRAIN;
                        end else begin
                            pass    <= pass + IDX_ONE;
                            j       <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        j       <= j_nxt;
                        swapped <= swapped || do_swap;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx <= '0;
                            state  <= ST_LOAD;
                        end else begin
                            rd_idx <= rd_idx + IDX_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_LOAD);
    assign busy      = (state == ST_CMP);
    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? entry[rd_idx] : 8'h00;
    assign out_last  = out_valid && (rd_idx == LAST_IDX);

endmodule
